// File: rtl/qs_pkg.sv
// Shared types, header field positions and sizing helpers for the quick-send decompressor.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package qs_pkg;

    localparam int QS_ROWS  = 32;
    localparam int QS_PIX   = 8;
    localparam int QS_IDX_W = $clog2(QS_ROWS);

    // Block header layout
    localparam int HDR_BASE_MSB  = 47;
    localparam int HDR_BASE_LSB  = 44;
    localparam int HDR_WCODE_MSB = 43;
    localparam int HDR_WCODE_LSB = 42;
    localparam int HDR_RSVD_MSB  = 41;
    localparam int HDR_RSVD_LSB  = 32;
    localparam int HDR_MASK_MSB  = 31;
    localparam int HDR_MASK_LSB  = 0;

    typedef logic [3:0] pixel_t;
    typedef pixel_t [QS_PIX-1:0] row_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ROWS = 1'b1
    } qs_state_t;

    // Payload words for a block: ceil(8 * W * non_uniform_rows / 32).
    function automatic logic [5:0] qs_words_needed(input logic [2:0] w, input logic [31:0] m);
        int ones;
        int bits;
        ones = 0;
        for (int i = 0; i < QS_ROWS; i++) begin
            if (!m[i]) ones++;
        end
        bits = ones * 8 * int'(w);
        return 6'((bits + 31) / 32);
    endfunction

endpackage

// File: rtl/qs_bit_unpacker.sv
// Bit buffer for the decompressor: appends 32-bit payload words, pops 8*W-bit rows, slices 8 W-bit deltas.
// Latency: a word appended in cycle t is visible in count/fields in cycle t+1.
// Backpressure: none internally; the caller only appends when count <= 32 so the 64-bit buffer never overflows.
// Ports: w (delta width 1..4), clear/shift/append controls, data (payload word), count (valid bits),
//        have_row (a full row is buffered), fields (8 zero-extended deltas of the oldest row).
// Optional: QS_DECOMP_PAD_CHECK_EN adds rest_nz (bits beyond the oldest row nonzero) and buf_nz (buffer nonzero).
module qs_bit_unpacker
    import qs_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  w,
    input  logic        clear,
    input  logic        shift,
    input  logic        append,
    input  logic [31:0] data,
    output logic [6:0]  count,
`ifdef QS_DECOMP_PAD_CHECK_EN
    output logic        rest_nz,
    output logic        buf_nz,
`endif
    output logic        have_row,
    output row_t        fields
);

    logic [63:0] buf_q;
    logic [63:0] buf_d;
    logic [6:0]  cnt_d;
    logic [5:0]  row_bits;
    logic [3:0]  wmask;

    assign row_bits = {w, 3'b000};
    assign have_row = (count >= {1'b0, row_bits});

    always_comb begin
        case (w)
            3'd1:    wmask = 4'h1;
            3'd2:    wmask = 4'h3;
            3'd3:    wmask = 4'h7;
            default: wmask = 4'hF;
        endcase
    end

    always_comb begin
        fields = '0;
        for (int p = 0; p < QS_PIX; p++) begin
            fields[p] = 4'(buf_q >> (6'(p) * {3'b000, w})) & wmask;
        end
    end

`ifdef QS_DECOMP_PAD_CHECK_EN
    // Bits above count are always zero, so any set bit here is payload padding.
    assign rest_nz = |(buf_q >> row_bits);
    assign buf_nz  = |buf_q;
`endif

    // Pop first, then append at the post-pop fill level.
    always_comb begin
        buf_d = buf_q;
        cnt_d = count;
        if (shift) begin
            buf_d = buf_q >> row_bits;
            cnt_d = count - {1'b0, row_bits};
        end
        if (append) begin
            buf_d = buf_d | ({32'b0, data} << cnt_d);
            cnt_d = cnt_d + 7'd32;
        end
        if (clear) begin
            buf_d = '0;
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q <= '0;
            count <= '0;
        end else begin
            buf_q <= buf_d;
            count <= cnt_d;
        end
    end

endmodule

// File: rtl/qs_decompressor.sv
// Rebuilds a 32x8x4-bit block from a 48-bit header plus packed delta payload, one row per beat.
// Latency: first row 1 cycle after the header (uniform row 0) or after the word completing row 0.
// Backpressure: out_ready stalls rows with outputs held; in_ready falls once the bit buffer holds > 32 bits.
// Ports: hdr_valid/hdr_ready/hdr/hdr_compressable (header), in_valid/in_ready/in_data (payload words),
//        out_valid/out_ready/out_row/out_idx/out_last (rows). Optional pad_err under QS_DECOMP_PAD_CHECK_EN.
module qs_decompressor
    import qs_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                hdr_valid,
    output logic                hdr_ready,
    input  logic [47:0]         hdr,
    input  logic                hdr_compressable,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output row_t                out_row,
    output logic [QS_IDX_W-1:0] out_idx,
`ifdef QS_DECOMP_PAD_CHECK_EN
    output logic                pad_err,
`endif
    output logic                out_last
);

    qs_state_t           state_q, state_d;
    logic [3:0]          base_q;
    logic [2:0]          w_q;
    logic [31:0]         mask_q;
    logic [QS_IDX_W-1:0] row_q;
    logic [5:0]          words_left_q;

    logic [3:0]  hdr_base;
    logic [2:0]  hdr_w;
    logic [31:0] hdr_mask;
    logic        hdr_rsvd_unused;

    logic       hdr_fire, in_fire, out_fire;
    logic       row_uniform, last_row;
    logic [6:0] count;
    logic       have_row;
    row_t       fields;
`ifdef QS_DECOMP_PAD_CHECK_EN
    logic       rest_nz, buf_nz;
`endif

    // Raw blocks reuse the compressed path with W=4, B=0 and no uniform rows.
    assign hdr_base = hdr_compressable ? hdr[HDR_BASE_MSB:HDR_BASE_LSB] : 4'd0;
    assign hdr_w    = hdr_compressable ? ({1'b0, hdr[HDR_WCODE_MSB:HDR_WCODE_LSB]} + 3'd1) : 3'd4;
    assign hdr_mask = hdr_compressable ? hdr[HDR_MASK_MSB:HDR_MASK_LSB] : 32'd0;
    assign hdr_rsvd_unused = ^hdr[HDR_RSVD_MSB:HDR_RSVD_LSB];

    assign hdr_fire    = hdr_valid && hdr_ready;
    assign in_fire     = in_valid && in_ready;
    assign out_fire    = out_valid && out_ready;
    assign row_uniform = mask_q[row_q];
    assign last_row    = (row_q == QS_IDX_W'(QS_ROWS - 1));

    qs_bit_unpacker u_unpacker (
        .clk      (clk),
        .rst_n    (rst_n),
        .w        (w_q),
        .clear    (out_fire && last_row),
        .shift    (out_fire && !row_uniform),
        .append   (in_fire),
        .data     (in_data),
        .count    (count),
`ifdef QS_DECOMP_PAD_CHECK_EN
        .rest_nz  (rest_nz),
        .buf_nz   (buf_nz),
`endif
        .have_row (have_row),
        .fields   (fields)
    );

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (hdr_fire) state_d = ST_ROWS;
            ST_ROWS: if (out_fire && last_row) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM: handshake outputs
    always_comb begin
        hdr_ready = (state_q == ST_IDLE);
        in_ready  = (state_q == ST_ROWS) && (words_left_q != 6'd0) && (count <= 7'd32);
        out_valid = (state_q == ST_ROWS) && (row_uniform || have_row);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q       <= '0;
            w_q          <= 3'd4;
            mask_q       <= '0;
            row_q        <= '0;
            words_left_q <= '0;
        end else begin
            if (hdr_fire) begin
                base_q       <= hdr_base;
                w_q          <= hdr_w;
                mask_q       <= hdr_mask;
                row_q        <= '0;
                words_left_q <= qs_words_needed(hdr_w, hdr_mask);
            end
            if (in_fire) words_left_q <= words_left_q - 6'd1;
            if (out_fire) row_q <= last_row ? '0 : row_q + 1'b1;
        end
    end

    // Rows are decoded from registered state only; the buffer can grow under a stalled row
    // but the oldest row's bits never move until it is popped, so the beat stays stable.
    always_comb begin
        out_row = '0;
        if (out_valid) begin
            for (int p = 0; p < QS_PIX; p++) begin
                out_row[p] = row_uniform ? base_q : (base_q + fields[p]);
            end
        end
    end

    assign out_idx  = row_q;
    assign out_last = out_valid && last_row;

`ifdef QS_DECOMP_PAD_CHECK_EN
    // On the last beat every payload word is in; whatever row 31 does not consume is padding.
    assign pad_err = out_last && (row_uniform ? buf_nz : rest_nz);
`endif

endmodule

// File: tb/tb_qs_decompressor.sv
module tb_qs_decompressor;
    import qs_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        hdr_valid;
    logic        hdr_ready;
    logic [47:0] hdr;
    logic        hdr_compressable;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    row_t        out_row;
    logic [4:0]  out_idx;
    logic        out_last;
`ifdef QS_DECOMP_PAD_CHECK_EN
    logic        pad_err;
`endif

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [31:0] words[$];
    logic [31:0] exp_rows[32];
    logic        exp_pad;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    qs_decompressor dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .hdr_valid        (hdr_valid),
        .hdr_ready        (hdr_ready),
        .hdr              (hdr),
        .hdr_compressable (hdr_compressable),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_data          (in_data),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_row          (out_row),
        .out_idx          (out_idx),
`ifdef QS_DECOMP_PAD_CHECK_EN
        .pad_err          (pad_err),
`endif
        .out_last         (out_last)
    );

    // Golden row builder from the words queue (LSB-first, row then pixel order).
    task automatic build_exp(input logic [3:0] b, input int w, input logic [31:0] m);
        int pos;
        logic [31:0] wv;
        logic [3:0]  d;
        logic [31:0] row;
        pos = 0;
        for (int r = 0; r < 32; r++) begin
            row = '0;
            for (int p = 0; p < 8; p++) begin
                if (m[r]) begin
                    row[p*4 +: 4] = b;
                end else begin
                    d = 4'd0;
                    for (int k = 0; k < w; k++) begin
                        wv = words[pos / 32];
                        d[k] = wv[pos % 32];
                        pos++;
                    end
                    row[p*4 +: 4] = b + d;
                end
            end
            exp_rows[r] = row;
        end
    endtask

    // Caller is at a negedge; returns at the negedge after the header handshake.
    task automatic send_hdr(input logic [3:0] b, input logic [1:0] code, input logic [31:0] m,
                            input logic comp);
        int guard;
        guard = 0;
        hdr = {b, code, 10'h3A5, m};
        hdr_compressable = comp;
        hdr_valid = 1'b1;
        while (!hdr_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        total++;
        if (!hdr_ready) begin
            $display("FAIL hdr_accept: hdr_ready=%0b required 1 within 100 cycles", hdr_ready);
            bad++;
        end
        @(negedge clk);
        hdr_valid = 1'b0;
    endtask

    task automatic feed(input int gap);
        int i;
        int guard;
        logic acc;
        i = 0;
        guard = 0;
        while (i < words.size()) begin
            in_valid = ($urandom_range(99) >= gap);
            in_data  = words[i];
            acc = in_valid && in_ready;
            @(negedge clk);
            if (acc) i++;
            guard++;
            if (guard > 3000) begin
                total++;
                bad++;
                $display("FAIL feed_timeout: accepted=%0d required=%0d", i, words.size());
                break;
            end
        end
        in_valid = 1'b0;
        total++;
        if (in_ready !== 1'b0) begin
            $display("FAIL in_ready_drop: in_ready=%0b required 0 after last word", in_ready);
            bad++;
        end
    endtask

    task automatic collect(input int gap, input logic chk_tp);
        int r;
        int guard;
        int first_valid;
        int last_fire;
        r = 0;
        guard = 0;
        first_valid = -1;
        last_fire = 0;
        while (r < 32) begin
            out_ready = ($urandom_range(99) >= gap);
            if (out_valid) begin
                if (first_valid < 0) first_valid = cyc;
                total++;
                if (out_row !== exp_rows[r]) begin
                    $display("FAIL row_data r=%0d: got %h required %h", r, out_row, exp_rows[r]);
                    bad++;
                end
                total++;
                if (out_idx !== 5'(r)) begin
                    $display("FAIL row_idx: got %0d required %0d", out_idx, r);
                    bad++;
                end
                total++;
                if (out_last !== (r == 31)) begin
                    $display("FAIL row_last r=%0d: got %0b required %0b", r, out_last, (r == 31));
                    bad++;
                end
`ifdef QS_DECOMP_PAD_CHECK_EN
                total++;
                if (pad_err !== ((r == 31) ? exp_pad : 1'b0)) begin
                    $display("FAIL pad_err r=%0d: got %0b required %0b", r, pad_err,
                             ((r == 31) ? exp_pad : 1'b0));
                    bad++;
                end
`endif
                if (out_ready) begin
                    last_fire = cyc;
                    r++;
                end
            end
            @(negedge clk);
            guard++;
            if (guard > 4000) begin
                total++;
                bad++;
                $display("FAIL collect_timeout: rows=%0d required 32", r);
                break;
            end
        end
        out_ready = 1'b0;
        if (chk_tp) begin
            total++;
            if (last_fire - first_valid != 31) begin
                $display("FAIL throughput: span=%0d required 31", last_fire - first_valid);
                bad++;
            end
        end
        total++;
        if (hdr_ready !== 1'b1 || out_valid !== 1'b0) begin
            $display("FAIL block_end: hdr_ready=%0b out_valid=%0b required 1/0", hdr_ready, out_valid);
            bad++;
        end
    endtask

    task automatic run_block(input int in_gap, input int out_gap, input logic chk_tp);
        fork
            feed(in_gap);
            collect(out_gap, chk_tp);
        join
    endtask

    task automatic check_reset_values(input string tag);
        total++;
        if (hdr_ready !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0 ||
            out_row !== 32'h0 || out_idx !== 5'd0 || out_last !== 1'b0) begin
            $display("FAIL %s: hdr_ready=%0b in_ready=%0b out_valid=%0b row=%h idx=%0d last=%0b required 1 0 0 0 0 0",
                     tag, hdr_ready, in_ready, out_valid, out_row, out_idx, out_last);
            bad++;
        end
`ifdef QS_DECOMP_PAD_CHECK_EN
        total++;
        if (pad_err !== 1'b0) begin
            $display("FAIL %s_pad: pad_err=%0b required 0", tag, pad_err);
            bad++;
        end
`endif
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("reset_values");
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_values("post_reset_idle");
    endtask

    task automatic test_raw();
        words.delete();
        for (int i = 0; i < 32; i++) words.push_back(32'h76543210);
        for (int r = 0; r < 32; r++) exp_rows[r] = 32'h76543210;
        exp_pad = 1'b0;
        // Header fields must be ignored for a raw block.
        send_hdr(4'h9, 2'd0, 32'hFFFF0000, 1'b0);
        run_block(0, 0, 1'b1);
    endtask

    task automatic test_w2();
        words.delete();
        words.push_back(32'h0000E4E4);
        exp_rows[0] = 32'h10FE10FE;
        for (int r = 1; r < 32; r++) exp_rows[r] = 32'hEEEEEEEE;
        exp_pad = 1'b0;
        send_hdr(4'hE, 2'd1, 32'hFFFFFFFE, 1'b1);
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            $display("FAIL w2_start: in_ready=%0b out_valid=%0b required 1/0", in_ready, out_valid);
            bad++;
        end
        run_block(0, 50, 1'b0);
    endtask

    task automatic test_uniform();
        words.delete();
        for (int r = 0; r < 32; r++) exp_rows[r] = 32'h55555555;
        exp_pad = 1'b0;
        send_hdr(4'h5, 2'd0, 32'hFFFFFFFF, 1'b1);
        total++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            $display("FAIL uniform_first: out_valid=%0b in_ready=%0b required 1/0", out_valid, in_ready);
            bad++;
        end
        run_block(0, 0, 1'b1);
        // collect() leaves us 1 cycle after the out_last handshake: header must go straight in.
        send_hdr(4'h5, 2'd3, 32'hFFFFFFFF, 1'b1);
        total++;
        if (out_valid !== 1'b1) begin
            $display("FAIL uniform_b2b: out_valid=%0b required 1", out_valid);
            bad++;
        end
        run_block(0, 30, 1'b0);
    endtask

    task automatic test_w3_stall();
        words.delete();
        for (int i = 0; i < 24; i++) words.push_back($urandom);
        build_exp(4'hA, 3, 32'h0);
        exp_pad = 1'b0;
        send_hdr(4'hA, 2'd2, 32'h0, 1'b1);
        run_block(40, 40, 1'b0);
    endtask

    task automatic test_reset_mid();
        int guard;
        guard = 0;
        send_hdr(4'h0, 2'd0, 32'h0, 1'b0);
        in_valid  = 1'b1;
        in_data   = 32'h76543210;
        out_ready = 1'b1;
        while (!(out_valid && out_idx == 5'd10) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        total++;
        if (!(out_valid && out_idx == 5'd10)) begin
            $display("FAIL reset_mid_reach: idx=%0d valid=%0b required 10/1", out_idx, out_valid);
            bad++;
        end
        #2 rst_n = 1'b0;
        #1;
        check_reset_values("reset_async");
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_values("reset_no_rows");
        test_w2();
    endtask

`ifdef QS_DECOMP_PAD_CHECK_EN
    task automatic test_pad();
        words.delete();
        words.push_back(32'hDEADBEEF);
        build_exp(4'h3, 1, 32'hFFFFFFF0);
        exp_pad = 1'b0;
        send_hdr(4'h3, 2'd0, 32'hFFFFFFF0, 1'b1);
        run_block(0, 20, 1'b0);

        words.delete();
        words.push_back(32'h01A53C0F);
        build_exp(4'h3, 1, 32'hFFFFFFF8);
        exp_pad = 1'b1;
        send_hdr(4'h3, 2'd0, 32'hFFFFFFF8, 1'b1);
        run_block(0, 20, 1'b0);

        words.delete();
        words.push_back(32'h00A53C0F);
        build_exp(4'h3, 1, 32'hFFFFFFF8);
        exp_pad = 1'b0;
        send_hdr(4'h3, 2'd0, 32'hFFFFFFF8, 1'b1);
        run_block(0, 20, 1'b0);
    endtask
`endif

    initial begin
        rst_n            = 1'b0;
        hdr_valid        = 1'b0;
        hdr              = '0;
        hdr_compressable = 1'b0;
        in_valid         = 1'b0;
        in_data          = '0;
        out_ready        = 1'b0;
        exp_pad          = 1'b0;

        test_reset();
        test_raw();
        test_w2();
        test_uniform();
        test_w3_stall();
        test_reset_mid();
`ifdef QS_DECOMP_PAD_CHECK_EN
        test_pad();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
